// File: rtl/tmds_encoder.sv
// Single-channel DVI/TMDS 8b/10b encoder: transition minimisation in stage 1,
// DC balance with running disparity in stage 2, one symbol per pixel clock.
module tmds_encoder #(
    parameter logic [9:0] RST_SYMBOL = 10'h354
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_de,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    output logic [9:0] o_tmds,
    output logic [4:0] o_disparity
);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    logic [3:0]        n1d_s;
    logic              xnor_mode_s;
    logic [8:0]        q_m_s;
    logic [8:0]        q_m_r;
    logic              de_r;
    logic [1:0]        ctrl_r;

    logic [3:0]        n1_s;
    logic signed [4:0] diff_s;
    logic signed [4:0] cnt_r;
    logic signed [4:0] cnt_nxt_s;
    logic              cnt_pos_s;
    logic              cnt_neg_s;
    logic [9:0]        tmds_nxt_s;
    logic [9:0]        tmds_r;

    // Stage 1 combinational: choose XOR/XNOR chain to minimise transitions
    always_comb begin
        n1d_s       = popcount8(i_data);
        xnor_mode_s = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (i_data[0] == 1'b0));
        q_m_s       = 9'd0;
        q_m_s[0]    = i_data[0];
        for (int i = 1; i < 8; i++) begin
            if (xnor_mode_s) begin
                q_m_s[i] = ~(q_m_s[i-1] ^ i_data[i]);
            end else begin
                q_m_s[i] = q_m_s[i-1] ^ i_data[i];
            end
        end
        q_m_s[8] = ~xnor_mode_s;
    end

    // Stage 1 registers: q_m with de/ctrl delayed alongside
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_m_r  <= 9'd0;
            de_r   <= 1'b0;
            ctrl_r <= 2'b00;
        end else begin
            q_m_r  <= q_m_s;
            de_r   <= i_de;
            ctrl_r <= i_ctrl;
        end
    end

    // Stage 2 combinational: DC balance decision and next disparity.
    // Disparity stays within +-10, so a 5-bit modular sum equals the
    // 6-bit sum truncated to 5 bits.
    always_comb begin
        n1_s       = popcount8(q_m_r[7:0]);
        diff_s     = $signed({n1_s, 1'b0}) - 5'sd8;
        cnt_pos_s  = (cnt_r[4] == 1'b0) && (cnt_r != 5'sd0);
        cnt_neg_s  = cnt_r[4];
        tmds_nxt_s = RST_SYMBOL;
        cnt_nxt_s  = 5'sd0;
        if (!de_r) begin
            case (ctrl_r)
                2'b00:   tmds_nxt_s = 10'b1101010100;
                2'b01:   tmds_nxt_s = 10'b0010101011;
                2'b10:   tmds_nxt_s = 10'b0101010100;
                2'b11:   tmds_nxt_s = 10'b1010101011;
                default: tmds_nxt_s = RST_SYMBOL;
            endcase
            cnt_nxt_s = 5'sd0;
        end else if ((cnt_r == 5'sd0) || (n1_s == 4'd4)) begin
            tmds_nxt_s = {~q_m_r[8], q_m_r[8], (q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0])};
            cnt_nxt_s  = q_m_r[8] ? (cnt_r + diff_s) : (cnt_r - diff_s);
        end else if ((cnt_pos_s && (n1_s > 4'd4)) || (cnt_neg_s && (n1_s < 4'd4))) begin
            tmds_nxt_s = {1'b1, q_m_r[8], ~q_m_r[7:0]};
            cnt_nxt_s  = cnt_r + (q_m_r[8] ? 5'sd2 : 5'sd0) - diff_s;
        end else begin
            tmds_nxt_s = {1'b0, q_m_r[8], q_m_r[7:0]};
            cnt_nxt_s  = cnt_r + diff_s - (q_m_r[8] ? 5'sd0 : 5'sd2);
        end
    end

    // Stage 2 registers: output symbol and running disparity
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmds_r <= RST_SYMBOL;
            cnt_r  <= 5'sd0;
        end else begin
            tmds_r <= tmds_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign o_tmds      = tmds_r;
    assign o_disparity = cnt_r;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed vector table, then randomized traffic
// against an integer-arithmetic reference encoder with a 2-deep pipeline queue.
module tb_tmds_encoder;

    logic       clk;
    logic       rst;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [9:0] tmds;
    logic [4:0] disp;

    int n_cmp  = 0;
    int n_fail = 0;

    tmds_encoder dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_de        (de),
        .i_data      (data),
        .i_ctrl      (ctrl),
        .o_tmds      (tmds),
        .o_disparity (disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic [9:0] exp_tmds;
        int         exp_disp;
    } vec_t;

    typedef struct {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } in_t;

    vec_t vq[$];
    in_t  pipe[$];
    int   m_cnt;

    task automatic add_vec(input logic r, input logic d, input logic [1:0] c,
                           input logic [7:0] b, input logic [9:0] et, input int ed);
        vec_t v;
        v.rst = r; v.de = d; v.ctrl = c; v.data = b; v.exp_tmds = et; v.exp_disp = ed;
        vq.push_back(v);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 10'h%03h, expected 10'h%03h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder, written from the encoding rules in plain integers.
    function automatic logic [9:0] ref_encode(input logic d_en, input logic [1:0] c,
                                              input logic [7:0] b);
        int         ones;
        int         n1;
        int         n0;
        bit         use_xnor;
        logic [8:0] qm;
        logic [9:0] sym;
        if (!d_en) begin
            m_cnt = 0;
            case (c)
                2'b00:   return 10'h354;
                2'b01:   return 10'h0AB;
                2'b10:   return 10'h154;
                default: return 10'h2AB;
            endcase
        end
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        use_xnor = (ones > 4) || (ones == 4 && b[0] == 1'b0);
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
        qm[8] = !use_xnor;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        n0 = 8 - n1;
        if (m_cnt == 0 || n1 == n0) begin
            sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            m_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            m_cnt += 2 * int'(qm[8]) + (n0 - n1);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            m_cnt += (n1 - n0) - 2 * (qm[8] ? 0 : 1);
        end
        return sym;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] sym);
        logic [7:0] d;
        logic [7:0] o;
        d = sym[9] ? ~sym[7:0] : sym[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    initial begin
        vec_t       v;
        in_t        cur;
        in_t        old;
        logic [9:0] exp_sym;
        int         sd;

        rst = 1'b1; de = 1'b1; data = 8'hAA; ctrl = 2'b00;

        for (int i = 0; i < 10; i++) add_vec(1'b1, 1'b1, 2'b00, 8'hAA, 10'h354, 0);
        add_vec(1'b0, 1'b0, 2'b00, 8'hAA, 10'h354, 0);
        add_vec(1'b0, 1'b0, 2'b01, 8'h5C, 10'h354, 0);
        add_vec(1'b0, 1'b0, 2'b10, 8'hFF, 10'h0AB, 0);
        add_vec(1'b0, 1'b0, 2'b11, 8'h00, 10'h154, 0);
        add_vec(1'b0, 1'b1, 2'b11, 8'h00, 10'h2AB, 0);
        add_vec(1'b0, 1'b1, 2'b10, 8'h00, 10'h100, -8);
        add_vec(1'b0, 1'b1, 2'b01, 8'h00, 10'h3FF, 2);
        add_vec(1'b0, 1'b0, 2'b00, 8'h12, 10'h100, -6);
        add_vec(1'b0, 1'b1, 2'b00, 8'hFF, 10'h354, 0);
        add_vec(1'b0, 1'b0, 2'b00, 8'h00, 10'h200, -8);
        add_vec(1'b0, 1'b0, 2'b00, 8'h00, 10'h354, 0);
        add_vec(1'b0, 1'b1, 2'b00, 8'h00, 10'h354, 0);
        add_vec(1'b0, 1'b1, 2'b00, 8'h00, 10'h100, -8);
        add_vec(1'b1, 1'b1, 2'b00, 8'h00, 10'h354, 0);
        add_vec(1'b0, 1'b1, 2'b00, 8'h00, 10'h354, 0);
        add_vec(1'b0, 1'b1, 2'b00, 8'h00, 10'h100, -8);
        add_vec(1'b0, 1'b1, 2'b00, 8'h00, 10'h3FF, 2);

        foreach (vq[k]) begin
            v = vq[k];
            @(negedge clk);
            rst = v.rst; de = v.de; ctrl = v.ctrl; data = v.data;
            @(posedge clk);
            #1;
            check_sym($sformatf("vec%0d_tmds", k), tmds, v.exp_tmds);
            check_int($sformatf("vec%0d_disp", k), int'($signed(disp)), v.exp_disp);
        end

        // Randomized traffic with occasional resets
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        pipe.delete();
        old.de = 1'b0; old.ctrl = 2'b00; old.data = 8'h00;
        pipe.push_back(old);
        m_cnt = 0;
        check_sym("rand_rst_tmds", tmds, 10'h354);

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 499) == 0);
            de   = ($urandom_range(0, 3) != 0);
            ctrl = 2'($urandom_range(0, 3));
            data = 8'($urandom);
            cur.de = de; cur.ctrl = ctrl; cur.data = data;
            @(posedge clk);
            #1;
            if (rst) begin
                pipe.delete();
                old.de = 1'b0; old.ctrl = 2'b00; old.data = 8'h00;
                pipe.push_back(old);
                m_cnt = 0;
                exp_sym = 10'h354;
            end else begin
                pipe.push_back(cur);
                old = pipe.pop_front();
                exp_sym = ref_encode(old.de, old.ctrl, old.data);
            end
            check_sym("rand_tmds", tmds, exp_sym);
            sd = int'($signed(disp));
            check_int("rand_disp", sd, m_cnt);
            check_int("rand_disp_bound", ((sd <= 10) && (sd >= -10)) ? 1 : 0, 1);
            if (!rst && old.de) begin
                check_int("rand_decode", int'(decode(tmds)), int'(old.data));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
